// File: rtl/fetch_link_pkg.sv
// Shared types and width helpers for the fetch link controller and its FIFO.
package fetch_link_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StRelease} fetch_state_e;

  function automatic int unsigned fetch_beats(int unsigned instr_w, int unsigned bus_w);
    return instr_w / bus_w;
  endfunction

  function automatic int unsigned beat_addr_width(int unsigned instr_w, int unsigned bus_w);
    return $clog2(instr_w / bus_w);
  endfunction

  function automatic int unsigned fetch_addr_width(int unsigned pc_w, int unsigned instr_w,
                                                   int unsigned bus_w);
    return pc_w + beat_addr_width(instr_w, bus_w);
  endfunction

  function automatic int unsigned fifo_count_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned DefInstrWidth = 16;
  localparam int unsigned DefPcWidth    = 12;

  // Entry layout at the default widths; the controller builds the same layout at its own widths.
  typedef struct packed {
    logic [DefInstrWidth-1:0] instr;
    logic [DefPcWidth-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// First-word fall-through FIFO with synchronous flush; flush beats any same-cycle push or pop.
module fetch_fifo #(
  parameter int unsigned Width = 28,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_link_controller.sv
// Fetches instructions over a 4-phase req/ack byte link, prefetching into a FWFT FIFO,
// with program-end wrap and redirect-with-flush.
module fetch_link_controller
  import fetch_link_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned PC_WIDTH    = 12,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic                                                         fetch_enable,
  input  logic [PC_WIDTH-1:0]                                          prog_last,
  input  logic                                                         redirect_valid,
  input  logic [PC_WIDTH-1:0]                                          redirect_pc,
  input  logic [BUS_WIDTH-1:0]                                         ext_data_in,
  input  logic                                                         ext_ack,
  output logic                                                         ext_req,
  output logic [fetch_addr_width(PC_WIDTH, INSTR_WIDTH, BUS_WIDTH)-1:0] ext_addr_out,
  output logic                                                         instr_valid,
  input  logic                                                         instr_ready,
  output logic [INSTR_WIDTH-1:0]                                       instr,
  output logic [PC_WIDTH-1:0]                                          instr_pc,
  output logic [fifo_count_width(FIFO_DEPTH)-1:0]                      fifo_count,
  output logic                                                         busy
);

  localparam int unsigned Beats     = fetch_beats(INSTR_WIDTH, BUS_WIDTH);
  localparam int unsigned AddrBeatW = beat_addr_width(INSTR_WIDTH, BUS_WIDTH);
  localparam int unsigned BeatW     = (AddrBeatW > 0) ? AddrBeatW : 1;
  localparam int unsigned AddrW     = PC_WIDTH + AddrBeatW;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } entry_t;

  fetch_state_e           state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [BeatW-1:0]       beat_q, beat_d;
  logic                   discard_q, discard_d;
  logic                   ext_req_q, ext_req_d;
  logic [AddrW-1:0]       ext_addr_q, ext_addr_d;
  logic                   busy_q, busy_d;
  logic [INSTR_WIDTH-1:0] asm_q, asm_d;

  logic                ack_s, start_fetch, last_beat, finishing, push, fifo_full;
  logic [PC_WIDTH-1:0] next_pc, redirect_tgt;
  logic [BeatW-1:0]    beat_nxt;
  entry_t              push_entry, head_entry;

  // With a single beat the beat index carries no address bits and is shifted out.
  function automatic logic [AddrW-1:0] addr_of(logic [PC_WIDTH-1:0] pc, logic [BeatW-1:0] beat);
    logic [PC_WIDTH+BeatW-1:0] full;
    full = {pc, beat};
    return AddrW'(full >> (BeatW - AddrBeatW));
  endfunction

  assign ack_sync_d   = {ack_sync_q[SYNC_STAGES-2:0], ext_ack};
  assign ack_s        = ack_sync_q[SYNC_STAGES-1];
  assign start_fetch  = fetch_enable && !fifo_full && !redirect_valid;
  assign last_beat    = (beat_q == LastBeat);
  assign beat_nxt     = beat_q + BeatW'(1);
  assign finishing    = (state_q == StRelease) && !ack_s && last_beat;
  assign next_pc      = (fetch_pc_q == prog_last) ? '0 : fetch_pc_q + PC_WIDTH'(1);
  assign redirect_tgt = (redirect_pc > prog_last) ? '0 : redirect_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_fetch) state_d = StReq;
      StReq:     if (ack_s) state_d = StRelease;
      StRelease: if (!ack_s) state_d = last_beat ? StIdle : StReq;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    beat_d     = beat_q;
    discard_d  = discard_q;
    ext_req_d  = ext_req_q;
    ext_addr_d = ext_addr_q;
    busy_d     = busy_q;
    asm_d      = asm_q;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_fetch) begin
          ext_req_d  = 1'b1;
          ext_addr_d = addr_of(fetch_pc_q, beat_q);
          busy_d     = 1'b1;
        end
      end
      StReq: begin
        if (ack_s) begin
          asm_d[int'(beat_q) * BUS_WIDTH +: BUS_WIDTH] = ext_data_in;
          ext_req_d = 1'b0;
        end
      end
      StRelease: begin
        if (!ack_s) begin
          if (!last_beat) begin
            beat_d     = beat_nxt;
            ext_req_d  = 1'b1;
            ext_addr_d = addr_of(fetch_pc_q, beat_nxt);
          end else begin
            beat_d    = '0;
            push      = !discard_q && !redirect_valid;
            // A discarded fetch already had fetch_pc retargeted by the redirect.
            if (!discard_q) fetch_pc_d = next_pc;
            discard_d = 1'b0;
            busy_d    = 1'b0;
          end
        end
      end
      default: ;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      if (busy_q && !finishing) discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_sync_q <= '0;
      fetch_pc_q <= '0;
      beat_q     <= '0;
      discard_q  <= 1'b0;
      ext_req_q  <= 1'b0;
      ext_addr_q <= '0;
      busy_q     <= 1'b0;
      asm_q      <= '0;
    end else begin
      ack_sync_q <= ack_sync_d;
      fetch_pc_q <= fetch_pc_d;
      beat_q     <= beat_d;
      discard_q  <= discard_d;
      ext_req_q  <= ext_req_d;
      ext_addr_q <= ext_addr_d;
      busy_q     <= busy_d;
      asm_q      <= asm_d;
    end
  end

  assign push_entry = '{instr: asm_q, pc: fetch_pc_q};

  fetch_fifo #(
    .Width($bits(entry_t)),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .flush_i(redirect_valid),
    .push_i (push),
    .data_i (push_entry),
    .pop_i  (instr_ready),
    .data_o (head_entry),
    .valid_o(instr_valid),
    .full_o (fifo_full),
    .count_o(fifo_count)
  );

  always_comb begin
    ext_req      = ext_req_q;
    ext_addr_out = ext_addr_q;
    busy         = busy_q;
    instr        = instr_valid ? head_entry.instr : '0;
    instr_pc     = instr_valid ? head_entry.pc : '0;
  end

endmodule

// File: tb/tb_fetch_link_controller.sv
// Scoreboard bench for fetch_link_controller with a 4-phase host returning addr ^ 8'hA5.
module tb_fetch_link_controller;
  import fetch_link_pkg::*;

  localparam int unsigned AckDelay = 3;
  localparam int WaitSb   = 0;
  localparam int WaitFull = 1;
  localparam int WaitAddr = 2;
  localparam int WaitIdle = 3;
  localparam int WaitReq  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_enable = 1'b0;
  logic [11:0] prog_last = 12'd9;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = 12'd0;
  logic [7:0]  ext_data_in;
  logic        ext_ack;
  logic        ext_req;
  logic [12:0] ext_addr_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic [2:0]  fifo_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_entry_t sb_q[$];
  logic [12:0]  addr_log[$];

  // Word for PC p is {(2p+1)^A5, (2p)^A5}, worked out by hand.
  logic [15:0] exp_tab [10] = '{16'hA4A5, 16'hA6A7, 16'hA0A1, 16'hA2A3, 16'hACAD,
                                16'hAEAF, 16'hA8A9, 16'hAAAB, 16'hB4B5, 16'hB6B7};

  fetch_link_controller #(
    .BUS_WIDTH(8),
    .INSTR_WIDTH(16),
    .PC_WIDTH(12),
    .FIFO_DEPTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_enable  (fetch_enable),
    .prog_last     (prog_last),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ext_data_in   (ext_data_in),
    .ext_ack       (ext_ack),
    .ext_req       (ext_req),
    .ext_addr_out  (ext_addr_out),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fifo_count    (fifo_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input int pc);
    fetch_entry_t e;
    e.instr = exp_tab[pc];
    e.pc    = 12'(pc);
    sb_q.push_back(e);
  endtask

  task automatic wait_for(input string name, input int kind, input logic [12:0] addr,
                          input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #2;
      case (kind)
        WaitSb:   done = (sb_q.size() == 0);
        WaitFull: done = (fifo_count == 3'd4);
        WaitAddr: done = ext_req && (ext_addr_out == addr);
        WaitIdle: done = !busy;
        default:  done = ext_req;
      endcase
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: condition not reached in %0d cycles, required within budget", name,
               budget);
    end
  endtask

  task automatic stop_fetching();
    @(negedge clk);
    instr_ready  = 1'b0;
    fetch_enable = 1'b0;
    wait_for("stop_idle", WaitIdle, 13'd0, 200);
  endtask

  // Host: ack after a delay with data = addr ^ A5, release ack after req falls.
  initial begin : host
    logic [12:0] a;
    ext_ack     = 1'b0;
    ext_data_in = 8'h00;
    forever begin
      @(negedge clk);
      if (ext_req && !ext_ack) begin
        a = ext_addr_out;
        repeat (AckDelay - 1) @(negedge clk);
        ext_data_in = a[7:0] ^ 8'hA5;
        ext_ack     = 1'b1;
      end else if (!ext_req && ext_ack) begin
        repeat (AckDelay - 1) @(negedge clk);
        ext_ack = 1'b0;
      end
    end
  end

  initial begin : req_logger
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ext_req && !req_prev) addr_log.push_back(ext_addr_out);
      req_prev = ext_req;
    end
  end

  initial begin : monitor
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      #1;
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_instr: got pc=%0d instr=0x%0h, required no output",
                   instr_pc, instr);
        end else begin
          e = sb_q.pop_front();
          if (instr !== e.instr || instr_pc !== e.pc) begin
            n_fail++;
            $display("FAIL instr_out: got pc=%0d instr=0x%0h required pc=%0d instr=0x%0h",
                     instr_pc, instr, e.pc, e.instr);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", ext_req, 0);
    check("rst_addr", ext_addr_out, 0);
    check("rst_count", fifo_count, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_busy", busy, 0);

    // Fill with the consumer stalled: exactly four entries, then the link goes quiet.
    @(negedge clk);
    rst          = 1'b1;
    fetch_enable = 1'b1;
    for (int p = 0; p < 4; p++) expect_pc(p);
    wait_for("fill_full", WaitFull, 13'd0, 1000);
    repeat (40) @(negedge clk);
    check("full_req_low", ext_req, 0);
    check("full_count", fifo_count, 4);
    check("full_valid", instr_valid, 1);
    check("full_busy", busy, 0);
    check("addr_log_len", addr_log.size(), 8);
    for (int k = 0; k < 8; k++) check($sformatf("addr_seq_%0d", k), addr_log[k], k);

    // One pop frees a slot and the PC 4 fetch begins at byte address 8.
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    wait_for("pc4_start", WaitAddr, 13'd8, 200);
    fetch_enable = 1'b0;
    expect_pc(4);
    wait_for("pc4_done", WaitIdle, 13'd0, 200);
    @(negedge clk);
    check("refill_count", fifo_count, 4);
    instr_ready = 1'b1;
    wait_for("drain_1", WaitSb, 13'd0, 200);
    stop_fetching();

    // Out-of-range redirect lands on 0, then wrap with prog_last=2.
    redirect_pc    = 12'd20;
    redirect_valid = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    prog_last      = 12'd2;
    expect_pc(0); expect_pc(1); expect_pc(2); expect_pc(0); expect_pc(1);
    fetch_enable = 1'b1;
    instr_ready  = 1'b1;
    wait_for("wrap_seq", WaitSb, 13'd0, 3000);
    stop_fetching();

    // Flush leftovers, then redirect to 7 during beat 1 of PC 2.
    prog_last      = 12'd9;
    redirect_pc    = 12'd0;
    redirect_valid = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("flush_count", fifo_count, 0);
    check("flush_valid", instr_valid, 0);
    expect_pc(0); expect_pc(1);
    fetch_enable = 1'b1;
    instr_ready  = 1'b1;
    wait_for("pc2_beat1", WaitAddr, 13'd5, 1000);
    redirect_pc    = 12'd7;
    redirect_valid = 1'b1;
    expect_pc(7); expect_pc(8);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("redir_count", fifo_count, 0);
    check("redir_busy", busy, 1);
    wait_for("redir_seq", WaitSb, 13'd0, 3000);
    stop_fetching();

    // Asynchronous reset in the middle of a handshake.
    fetch_enable = 1'b1;
    wait_for("req_for_reset", WaitReq, 13'd0, 300);
    #1 rst = 1'b0;
    #1;
    check("arst_req", ext_req, 0);
    check("arst_addr", ext_addr_out, 0);
    check("arst_busy", busy, 0);
    check("arst_count", fifo_count, 0);
    check("arst_valid", instr_valid, 0);
    repeat (12) @(negedge clk);
    addr_log.delete();
    rst         = 1'b1;
    instr_ready = 1'b1;
    expect_pc(0);
    wait_for("restart_req", WaitReq, 13'd0, 100);
    check("restart_addr", addr_log[0], 0);
    wait_for("restart_seq", WaitSb, 13'd0, 500);
    stop_fetching();

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_link_controller.md
Name: fetch_link_controller

Overview:
- Parametrised successor of the single-byte asynchronous instruction loader. Fetches program words from an external, asynchronously clocked host over a 4-phase req/ack byte link.
- Assembles each instruction from BEATS = INSTR_WIDTH/BUS_WIDTH link beats and prefetches sequential instructions into a small FIFO. Hands them to the multiprocessor via valid/ready.
- Adds what the old loader lacked: configurable widths, a prefetch depth, program-end wrap, and redirect (jump) with flush.

Parameters:
- BUS_WIDTH, 8, link data width in bits.
- INSTR_WIDTH, 16, instruction width; must be an integer multiple of BUS_WIDTH.
- PC_WIDTH, 12, program counter width.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.
- SYNC_STAGES, 2, flip-flops in the ext_ack synchroniser; at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- fetch_enable  in  1  permits starting new instruction fetches.
- prog_last  in  PC_WIDTH  last valid PC; sequential fetch wraps to 0 after it.
- redirect_valid  in  1  one-cycle jump request.
- redirect_pc  in  PC_WIDTH  jump target.
- ext_data_in  in  BUS_WIDTH  link data; stable from ack rise until req fall.
- ext_ack  in  1  link acknowledge; asynchronous to clk.
- ext_req  out  1  link request.
- ext_addr_out  out  PC_WIDTH+clog2(BEATS)  byte address {fetch_pc, beat}; stable while ext_req is high.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  consumer accepts the head.
- instr  out  INSTR_WIDTH  head instruction.
- instr_pc  out  PC_WIDTH  PC of the head instruction.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- busy  out  1  a link handshake is in flight.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - ext_req=0, ext_addr_out=0, fetch_pc=0, beat=0, discard=0.
  - fifo_count=0, instr_valid=0, instr=0, instr_pc=0, busy=0.
  - Synchroniser flops cleared.
- Reset mid-handshake drops ext_req immediately. The host must tolerate an abandoned request.
- ack_s is ext_ack after SYNC_STAGES flops. All link decisions use ack_s only.
- FSM states and transitions:
  - IDLE: go to REQ when fetch_enable=1, fifo_count<FIFO_DEPTH and not redirecting this cycle. On that edge, ext_req<=1, ext_addr_out<={fetch_pc,beat}, busy<=1.
  - REQ: wait for ack_s=1. On that cycle, capture ext_data_in into assembly slot [beat*BUS_WIDTH +: BUS_WIDTH] (little-endian, beat 0 = LSBs). Set ext_req<=0 and go to RELEASE.
  - RELEASE: wait for ack_s=0.
    - If beat<BEATS-1: beat++, ext_req<=1 with the new address, return to REQ.
    - Otherwise: beat<=0, push {assembled, fetch_pc} unless discard, advance fetch_pc, clear discard, busy<=0, go to IDLE.
- fetch_pc advance: 0 if fetch_pc==prog_last, else fetch_pc+1.
- FIFO space rule:
  - The space check happens only at the start of an instruction, and at most one instruction is in flight, so a push never meets a full FIFO.
  - fetch_enable going low mid-instruction does not stop it; all BEATS are completed.
- FIFO behaviour:
  - First-word fall-through. instr_valid rises the cycle after a push into an empty FIFO.
  - Pop on instr_valid && instr_ready.
  - Simultaneous push and pop leaves fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Redirect (redirect_valid=1):
  - Flush the FIFO: count=0, pointers=0, instr_valid=0 next cycle. Redirect has priority over a same-cycle pop and push.
  - fetch_pc<=redirect_pc, or 0 if redirect_pc>prog_last.
  - If busy, set discard=1. The 4-phase handshake is never aborted: the in-flight instruction completes all beats, its data is dropped, and beat resets to 0.
  - A redirect in the same cycle a push would occur suppresses that push.
- Throughput: each beat costs at least 2*(SYNC_STAGES+1) cycles of handshake.

Decomposition:
- Package fetch_link_pkg holds:
  - the state enum (IDLE, REQ, RELEASE);
  - localparam functions for BEATS and address/count widths;
  - the fifo entry struct {instr, pc}.
- Sub-module fetch_fifo: a parametrised FWFT FIFO with flush, push, pop and count. It is reused later by the VGA/state path.
- Synchroniser kept inline.

Test Plan:
- Reset, enable, host model with 3-cycle ack delay returns byte = address ^ 8'hA5 → instructions at PC 0,1,2 appear in order. instr for PC 0 = 16'hA4A5 (byte address 1 gives A4, address 0 gives A5). ext_addr_out sequence 0,1,2,3,...
- instr_ready=0, prog_last=9 → exactly FIFO_DEPTH=4 entries (PC 0..3) and fifo_count=4. ext_req stays 0 afterwards. One pop → the PC 4 fetch starts.
- prog_last=2, continuous ready → instr_pc sequence 0,1,2,0,1.
- redirect_pc=7 asserted during beat 1 of PC 2 → the PC 2 word never appears, the FIFO empties, and the next instr_pc is 7.
- redirect_pc=20 with prog_last=9 → the next instr_pc is 0.
- rst pulsed low while ext_req=1 → ext_req=0 and outputs cleared asynchronously. After release, fetching restarts at address 0.
